// File: rtl/circular_dma_pkg.sv
//------------------------------------------------------------------------------
// Module  : circular_dma_pkg
// Purpose : Shared packer state encoding and lane-geometry helpers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package circular_dma_pkg;

    localparam int C_DEF_AXIS_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PACK    = 2'd1,
        ST_DISCARD = 2'd2
    } pack_state_e;

    function automatic int lanes_of(input int width);
        return width / 8;
    endfunction

    function automatic int idx_width_of(input int width);
        return $clog2(width / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/circular_dma_skid.sv
//------------------------------------------------------------------------------
// Module  : circular_dma_skid
// Purpose : Two-entry AXIS output buffer (data + tlast) with registered not-full.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module circular_dma_skid #(
    parameter int C_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [C_WIDTH-1:0] push_data_i,
    input  logic               push_last_i,
    output logic               not_full_o,
    output logic [C_WIDTH-1:0] m_tdata_o,
    output logic               m_tlast_o,
    output logic               m_tvalid_o,
    input  logic               m_tready_i
);

    logic [C_WIDTH:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             not_full_q;
    logic             w_pop;

    assign w_pop   = m_tvalid_o & m_tready_i;
    assign count_d = count_q + {1'b0, push_i} - {1'b0, w_pop};

    // not_full is precomputed from the next occupancy so the upstream ready
    // never depends combinationally on m_tready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            not_full_q <= 1'b1;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            not_full_q <= (count_d != 2'd2);
        end
    end

    assign not_full_o = not_full_q;
    assign m_tdata_o  = mem_q[rd_ptr_q][C_WIDTH-1:0];
    assign m_tlast_o  = mem_q[rd_ptr_q][C_WIDTH];
    assign m_tvalid_o = (count_q != 2'd0);

endmodule

`default_nettype wire

// File: rtl/circular_dma_packer.sv
//------------------------------------------------------------------------------
// Module  : circular_dma_packer
// Purpose : Packs a byte AXIS message stream into padded wide beats for S2MM.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module circular_dma_packer
    import circular_dma_pkg::*;
#(
    parameter int         C_AXIS_WIDTH    = C_DEF_AXIS_WIDTH,
    parameter int         C_MAX_MSG_WORDS = 256,
    parameter logic [7:0] C_PAD_BYTE      = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    clear_stats,
    output logic [31:0]             msg_count,
    output logic [31:0]             byte_count,
    output logic                    truncated,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [C_AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int              LANES    = lanes_of(C_AXIS_WIDTH);
    localparam int              IDX_W    = idx_width_of(C_AXIS_WIDTH);
    localparam int              WC_W     = $clog2(C_MAX_MSG_WORDS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(C_MAX_MSG_WORDS - 1);

    pack_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WC_W-1:0]         wc_q, wc_d;
    logic [C_AXIS_WIDTH-1:0] acc_q, acc_d;
    logic [31:0]             msg_count_q, byte_count_q;
    logic                    truncated_q;

    logic                    w_buf_not_full;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_push_last;
    logic                    w_set_trunc;
    logic [C_AXIS_WIDTH-1:0] w_beat;

    assign s_axis_tready = ((state_q == ST_PACK) & w_buf_not_full) | (state_q == ST_DISCARD);
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    // Lanes below idx come from the accumulator, the current byte lands at idx,
    // everything above is padding (only visible on a completing beat).
    always_comb begin
        w_beat = '0;
        for (int k = 0; k < LANES; k++) begin
            if (IDX_W'(k) < idx_q) begin
                w_beat[8*k +: 8] = acc_q[8*k +: 8];
            end else if (IDX_W'(k) == idx_q) begin
                w_beat[8*k +: 8] = s_axis_tdata;
            end else begin
                w_beat[8*k +: 8] = C_PAD_BYTE;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wc_d        = wc_q;
        acc_d       = acc_q;
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_set_trunc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_PACK;
                    idx_d   = '0;
                    wc_d    = '0;
                end
            end
            ST_PACK: begin
                if (w_accept) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (IDX_W'(k) == idx_q) begin
                            acc_d[8*k +: 8] = s_axis_tdata;
                        end
                    end
                    if ((idx_q == IDX_LAST) || s_axis_tlast) begin
                        w_push      = 1'b1;
                        w_push_last = s_axis_tlast | (wc_q == WC_LAST);
                        idx_d       = '0;
                        wc_d        = wc_q + 1'b1;
                        if (s_axis_tlast) begin
                            wc_d    = '0;
                            state_d = enable ? ST_PACK : ST_IDLE;
                        end else if (wc_q == WC_LAST) begin
                            wc_d        = '0;
                            w_set_trunc = 1'b1;
                            state_d     = ST_DISCARD;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (w_accept && s_axis_tlast) begin
                    state_d = enable ? ST_PACK : ST_IDLE;
                    idx_d   = '0;
                    wc_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wc_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wc_q    <= wc_d;
            acc_q   <= acc_d;
        end
    end

    // A clear in the same cycle as an increment takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_count_q  <= '0;
            byte_count_q <= '0;
            truncated_q  <= 1'b0;
        end else if (clear_stats) begin
            msg_count_q  <= '0;
            byte_count_q <= '0;
            truncated_q  <= 1'b0;
        end else begin
            if (w_accept && (state_q == ST_PACK)) begin
                byte_count_q <= byte_count_q + 32'd1;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                msg_count_q <= msg_count_q + 32'd1;
            end
            if (w_set_trunc) begin
                truncated_q <= 1'b1;
            end
        end
    end

    assign msg_count  = msg_count_q;
    assign byte_count = byte_count_q;
    assign truncated  = truncated_q;

    circular_dma_skid #(
        .C_WIDTH (C_AXIS_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (w_beat),
        .push_last_i (w_push_last),
        .not_full_o  (w_buf_not_full),
        .m_tdata_o   (m_axis_tdata),
        .m_tlast_o   (m_axis_tlast),
        .m_tvalid_o  (m_axis_tvalid),
        .m_tready_i  (m_axis_tready)
    );

endmodule

`default_nettype wire
